dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported data memory. It shares the memory between the CPU load/store stage (port A) and a secondary master (port B: loader/debug/DMA). Port A has fixed priority. A starvation counter guarantees port B service. It drives the memory's addr/dataW/enaR/enaW lines and returns registered read data with a valid strobe.

---
 rtl/dmem_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-ported data memory: fixed priority to port A,
// starvation force for port B. Optional ownership locking with DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        a_lock,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic        b_lock,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataW,
    output logic        mem_enaR,
    output logic        mem_enaW,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_b_wait;
    logic              r_oor;
    logic              r_a_gnt;
    logic              r_b_gnt;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [31:0]       r_a_rdata;
    logic [31:0]       r_b_rdata;
    logic              r_a_err;
    logic              r_b_err;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_dataW;
    logic              r_mem_enaR;
    logic              r_mem_enaW;

    logic w_a_oor;
    logic w_b_oor;
    logic w_own_a;
    logic w_own_b;
    logic w_locked;
    logic w_force_b;
    logic w_pick_a;
    logic w_pick_b;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    owner_t r_owner;
    owner_t w_owner_eff;
`else
    logic w_unused_lock;
    assign w_unused_lock = a_lock ^ b_lock;
`endif

    assign w_a_oor = |a_addr[31:ADDR_W];
    assign w_b_oor = |b_addr[31:ADDR_W];

    // Effective owner is the registered owner unless its lock has just dropped.
    always_comb begin
        w_own_a = 1'b0;
        w_own_b = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        w_owner_eff = OWN_NONE;
        if ((r_owner == OWN_A) && a_lock) begin
            w_own_a     = 1'b1;
            w_owner_eff = OWN_A;
        end else if ((r_owner == OWN_B) && b_lock) begin
            w_own_b     = 1'b1;
            w_owner_eff = OWN_B;
        end
`endif
        w_locked  = w_own_a || w_own_b;
        w_force_b = !w_locked && b_req && (r_b_wait == WAIT_MAX);
        w_pick_a  = 1'b0;
        w_pick_b  = 1'b0;
        if (w_own_a) begin
            w_pick_a = a_req;
        end else if (w_own_b) begin
            w_pick_b = b_req;
        end else if (w_force_b) begin
            w_pick_b = 1'b1;
        end else if (a_req) begin
            w_pick_a = 1'b1;
        end else begin
            w_pick_b = b_req;
        end
    end

    // Sequencer: arbitrate in IDLE, drive memory for one SERVE cycle, return data next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_b_wait    <= '0;
            r_oor       <= 1'b0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_a_err     <= 1'b0;
            r_b_err     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dataW <= '0;
            r_mem_enaR  <= 1'b0;
            r_mem_enaW  <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            r_owner     <= OWN_NONE;
`endif
        end else begin
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dataW <= '0;
            r_mem_enaR  <= 1'b0;
            r_mem_enaW  <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            r_owner     <= w_owner_eff;
`endif
            case (r_state)
                IDLE: begin
                    if (w_pick_a) begin
                        r_state     <= SERVE_A;
                        r_a_gnt     <= 1'b1;
                        r_oor       <= w_a_oor;
                        r_mem_addr  <= a_addr;
                        r_mem_dataW <= a_wdata;
                        r_mem_enaW  <= a_we && !w_a_oor;
                        r_mem_enaR  <= !a_we && !w_a_oor;
                        if (b_req && !w_locked && (r_b_wait != WAIT_MAX)) begin
                            r_b_wait <= r_b_wait + WAIT_W'(1);
                        end
`ifdef DMEM_ARB_LOCK_EN
                        if (a_lock) begin
                            r_owner <= OWN_A;
                        end
`endif
                    end else if (w_pick_b) begin
                        r_state     <= SERVE_B;
                        r_b_gnt     <= 1'b1;
                        r_oor       <= w_b_oor;
                        r_mem_addr  <= b_addr;
                        r_mem_dataW <= b_wdata;
                        r_mem_enaW  <= b_we && !w_b_oor;
                        r_mem_enaR  <= !b_we && !w_b_oor;
                        r_b_wait    <= '0;
`ifdef DMEM_ARB_LOCK_EN
                        if (b_lock) begin
                            r_owner <= OWN_B;
                        end
`endif
                    end
                end
                SERVE_A: begin
                    r_state <= IDLE;
                    if (r_oor || r_mem_enaR) begin
                        r_a_rvalid <= 1'b1;
                        r_a_err    <= r_oor;
                        r_a_rdata  <= r_oor ? 32'h0 : mem_data_out;
                    end
                end
                SERVE_B: begin
                    r_state <= IDLE;
                    if (r_oor || r_mem_enaR) begin
                        r_b_rvalid <= 1'b1;
                        r_b_err    <= r_oor;
                        r_b_rdata  <= r_oor ? 32'h0 : mem_data_out;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a_gnt     = r_a_gnt;
    assign b_gnt     = r_b_gnt;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign a_err     = r_a_err;
    assign b_err     = r_b_err;
    assign mem_addr  = r_mem_addr;
    assign mem_dataW = r_mem_dataW;
    assign mem_enaR  = r_mem_enaR;
    assign mem_enaW  = r_mem_enaW;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized requesters checked against
// a transaction-level reference model (lock scenario only when DMEM_ARB_LOCK_EN is defined).
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] mem_addr, mem_dataW, mem_data_out;
    logic        mem_enaR, mem_enaW;

    int total = 0;
    int bad   = 0;

    // Memory attached to the DUT, and the model's own view of memory contents.
    logic [31:0] mem     [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    // Reference model: which port holds the memory this cycle, and what it asked for.
    int          m_serve;
    int          b_wait;
    int          own;
    bit          s_we;
    logic [31:0] s_addr, s_wdata;
    bit          e_arv, e_brv, e_aerr, e_berr;
    logic [31:0] e_ard, e_brd;

    dmem_arbiter #(.ADDR_W(10), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_enaR(mem_enaR), .mem_enaW(mem_enaW),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_enaW) mem[mem_addr[9:0]] <= mem_dataW;
    end
    assign mem_data_out = mem[mem_addr[9:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_serve = 0; b_wait = 0; own = 0;
        e_arv = 0; e_brv = 0; e_aerr = 0; e_berr = 0; e_ard = 0; e_brd = 0;
    endtask

    task automatic chk_all();
        bit oor;
        oor = (s_addr[31:10] != 22'h0);
        chk("a_gnt", 32'(a_gnt), 32'(m_serve == 1));
        chk("b_gnt", 32'(b_gnt), 32'(m_serve == 2));
        chk("mem_addr", mem_addr, (m_serve != 0) ? s_addr : 32'h0);
        chk("mem_dataW", mem_dataW, (m_serve != 0) ? s_wdata : 32'h0);
        chk("mem_enaW", 32'(mem_enaW), 32'((m_serve != 0) && s_we && !oor));
        chk("mem_enaR", 32'(mem_enaR), 32'((m_serve != 0) && !s_we && !oor));
        chk("a_rvalid", 32'(a_rvalid), 32'(e_arv));
        chk("b_rvalid", 32'(b_rvalid), 32'(e_brv));
        chk("a_rdata", a_rdata, e_ard);
        chk("b_rdata", b_rdata, e_brd);
        if (e_arv) chk("a_err", 32'(a_err), 32'(e_aerr));
        if (e_brv) chk("b_err", 32'(b_err), 32'(e_berr));
    endtask

    // One clock: advance the model using the inputs present at the edge, then compare.
    task automatic step();
        int  win;
        bit  oor;
        @(posedge clk);
`ifdef DMEM_ARB_LOCK_EN
        if (own == 1 && !a_lock) own = 0;
        if (own == 2 && !b_lock) own = 0;
`endif
        e_arv = 0;
        e_brv = 0;
        if (m_serve != 0) begin
            oor = (s_addr[31:10] != 22'h0);
            if (oor || !s_we) begin
                if (m_serve == 1) begin
                    e_arv = 1; e_aerr = oor; e_ard = oor ? 32'h0 : ref_mem[s_addr[9:0]];
                end else begin
                    e_brv = 1; e_berr = oor; e_brd = oor ? 32'h0 : ref_mem[s_addr[9:0]];
                end
            end else begin
                ref_mem[s_addr[9:0]] = s_wdata;
            end
            m_serve = 0;
        end else begin
            win = 0;
            if (own == 1)                          win = a_req ? 1 : 0;
            else if (own == 2)                     win = b_req ? 2 : 0;
            else if (b_req && b_wait == LIMIT)     win = 2;
            else if (a_req)                        win = 1;
            else if (b_req)                        win = 2;
            if (win == 1 && b_req && own == 0 && b_wait < LIMIT) b_wait++;
            if (win == 2) b_wait = 0;
`ifdef DMEM_ARB_LOCK_EN
            if (win == 1 && a_lock) own = 1;
            if (win == 2 && b_lock) own = 2;
`endif
            m_serve = win;
            if (win == 1) begin s_we = a_we; s_addr = a_addr; s_wdata = a_wdata; end
            if (win == 2) begin s_we = b_we; s_addr = b_addr; s_wdata = b_wdata; end
        end
        #1;
        chk_all();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = 32'($urandom_range(15, 0));
        if ($urandom_range(9, 0) == 0) r = r | (32'h1 << $urandom_range(31, 10));
        return r;
    endfunction

    int exp_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    initial begin
        int  k;
        int  got;
        bit  a_fresh, b_fresh;

        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
        s_we = 0; s_addr = 0; s_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst = 1'b0;

        // A writes then reads back.
        a_req = 1; a_we = 1; a_addr = 32'd5; a_wdata = 32'hDEADBEEF;
        step(); step();
        a_req = 0;
        step();
        a_req = 1; a_we = 0; a_wdata = 32'h0;
        step();
        chk("rd_gnt", 32'(a_gnt), 32'h1);
        step();
        chk("rd_data", a_rdata, 32'hDEADBEEF);
        chk("rd_err", 32'(a_err), 32'h0);
        a_req = 0;
        step();

        // Contention with both requests held: starvation forces every fifth grant to B.
        a_req = 1; a_we = 0; a_addr = 32'd1;
        b_req = 1; b_we = 0; b_addr = 32'd2;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            got = a_gnt ? 1 : (b_gnt ? 2 : 0);
            if (got != 0 && k < 10) begin
                chk("contention_order", 32'(got), 32'(exp_seq[k]));
                k++;
            end
        end
        chk("contention_count", 32'(k), 32'd10);
        a_req = 0; b_req = 0;
        step();

        // Out-of-range read from B.
        b_req = 1; b_we = 0; b_addr = 32'h400;
        step();
        chk("oor_gnt", 32'(b_gnt), 32'h1);
        chk("oor_enaR", 32'(mem_enaR), 32'h0);
        step();
        chk("oor_err", 32'(b_err), 32'h1);
        chk("oor_rdata", b_rdata, 32'h0);
        b_req = 0;
        step();

        // Reset asserted during the SERVE cycle of a write.
        a_req = 1; a_we = 1; a_addr = 32'd7; a_wdata = 32'h1234;
        step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_enaW", 32'(mem_enaW), 32'h0);
        chk("rst_gnt", 32'(a_gnt), 32'h0);
        model_reset();
        a_req = 0;
        @(posedge clk);
        #1;
        chk_all();
        rst = 1'b0;
        a_req = 1; a_we = 0; a_wdata = 32'h0;
        step(); step();
        chk("rst_rdata", a_rdata, 32'h0);
        a_req = 0;
        step();

`ifdef DMEM_ARB_LOCK_EN
        // B locks for three writes while A waits.
        b_lock = 1; b_req = 1; b_we = 1; b_addr = 32'd20; b_wdata = 32'hA0;
        step();
        a_req = 1; a_we = 0; a_addr = 32'd20;
        step();
        b_addr = 32'd21; b_wdata = 32'hA1;
        step(); step();
        b_addr = 32'd22; b_wdata = 32'hA2;
        step();
        chk("lock_a_wait", 32'(a_gnt), 32'h0);
        step();
        b_lock = 0; b_req = 0;
        step();
        chk("lock_release_gnt", 32'(a_gnt), 32'h1);
        step();
        chk("lock_rdata", a_rdata, 32'hA0);
        a_req = 0;
        step();
`endif

        // Idle: nothing requested.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_enaR", 32'(mem_enaR), 32'h0);
        end

        // Randomized requesters obeying the hold-until-grant handshake.
        a_fresh = 0; b_fresh = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (m_serve == 1) a_fresh = 1;
            else if (a_fresh || !a_req) begin
                if ((a_fresh && $urandom_range(1, 0) == 1) || (!a_fresh && $urandom_range(2, 0) == 0)) begin
                    a_req = 1; a_we = 1'($urandom_range(1, 0)); a_addr = rand_addr(); a_wdata = $urandom;
                end else begin
                    a_req = 0;
                end
                a_fresh = 0;
            end
            if (m_serve == 2) b_fresh = 1;
            else if (b_fresh || !b_req) begin
                if ((b_fresh && $urandom_range(1, 0) == 1) || (!b_fresh && $urandom_range(2, 0) == 0)) begin
                    b_req = 1; b_we = 1'($urandom_range(1, 0)); b_addr = rand_addr(); b_wdata = $urandom;
                end else begin
                    b_req = 0;
                end
                b_fresh = 0;
            end
        end
        a_req = 0; b_req = 0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
